systolic_sequencer: RTL and testbench

//   Sequences one C = A x B product on the output-stationary MAC grid:
//   - accepts A (array_height_p x inner_p) then B (inner_p x array_width_p) as a row-major operand stream
//   - feeds skewed row/column operand wavefronts into the grid
//   - drains the array_height_p*array_width_p results to the downstream result FIFO
//   - clears the accumulators before the next job

---
 rtl/systolic_sequencer.sv | 146 ++++++++++++++
 tb/tb_systolic_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: loads A/B, feeds skewed wavefronts into the MAC grid, drains C.
// Revision 1.0
`default_nettype none

module systolic_sequencer #(
  parameter int width_p        = 8,
  parameter int array_height_p = 2,
  parameter int array_width_p  = 2,
  parameter int inner_p        = 2,
  parameter int mac_latency_p  = 1
) (
  input  logic                                              clk_i,
  input  logic                                              reset_n_i,
  input  logic                                              valid_i,
  input  logic [width_p-1:0]                                data_i,
  output logic                                              ready_o,
  output logic [array_height_p*width_p-1:0]                 row_data_o,
  output logic [array_width_p*width_p-1:0]                  col_data_o,
  output logic                                              array_en_o,
  output logic                                              array_clr_o,
  output logic [((array_height_p*array_width_p) > 1 ?
                 $clog2(array_height_p*array_width_p) : 1)-1:0] res_idx_o,
  input  logic [width_p-1:0]                                res_data_i,
  output logic                                              valid_o,
  output logic [width_p-1:0]                                data_o,
  input  logic                                              yumi_i,
  output logic                                              busy_o
);

  localparam int H         = array_height_p;
  localparam int W         = array_width_p;
  localparam int K         = inner_p;
  localparam int TOTAL     = H*K + K*W;
  localparam int FEED_LEN  = K + H + W - 2;
  localparam int HW        = H*W;
  localparam int LOAD_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int FEED_W    = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;
  localparam int WAIT_W    = (mac_latency_p > 1) ? $clog2(mac_latency_p) : 1;
  localparam int IDX_W     = (HW > 1) ? $clog2(HW) : 1;
  localparam int WAIT_LAST = (mac_latency_p > 0) ? mac_latency_p - 1 : 0;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [LOAD_W-1:0]   load_cnt;
  logic [FEED_W-1:0]   feed_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]    drain_cnt;
  logic [width_p-1:0]  a_mem [H][K];
  logic [width_p-1:0]  b_mem [K][W];

  logic load_fire, load_last, feed_last, wait_last, drain_fire, drain_last;

  assign load_fire  = (state == S_LOAD) && valid_i;
  assign load_last  = (load_cnt == LOAD_W'(TOTAL - 1));
  assign feed_last  = (feed_cnt == FEED_W'(FEED_LEN - 1));
  assign wait_last  = (wait_cnt == WAIT_W'(WAIT_LAST));
  assign drain_fire = (state == S_DRAIN) && yumi_i;
  assign drain_last = (drain_cnt == IDX_W'(HW - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (load_fire && load_last) state_next = S_CLEAR;
      S_CLEAR: state_next = S_FEED;
      S_FEED:  if (feed_last) state_next = (mac_latency_p == 0) ? S_DRAIN : S_WAIT;
      S_WAIT:  if (wait_last) state_next = S_DRAIN;
      S_DRAIN: if (drain_fire && drain_last) state_next = S_DONE;
      S_DONE:  state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      load_cnt  <= '0;
      feed_cnt  <= '0;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (load_fire) load_cnt <= load_last ? '0 : load_cnt + 1'b1;
      if (state == S_FEED) feed_cnt <= feed_last ? '0 : feed_cnt + 1'b1;
      if (state == S_WAIT) wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
      if (drain_fire) drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
    end
  end

  // Word index decides the destination: A row-major first, then B row-major.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < H; r++)
        for (int k = 0; k < K; k++)
          a_mem[r][k] <= '0;
      for (int k = 0; k < K; k++)
        for (int c = 0; c < W; c++)
          b_mem[k][c] <= '0;
    end else if (load_fire) begin
      for (int r = 0; r < H; r++)
        for (int k = 0; k < K; k++)
          if (load_cnt == LOAD_W'(r*K + k)) a_mem[r][k] <= data_i;
      for (int k = 0; k < K; k++)
        for (int c = 0; c < W; c++)
          if (load_cnt == LOAD_W'(H*K + k*W + c)) b_mem[k][c] <= data_i;
    end
  end

  // Row r lags by r steps and column c by c steps, so operand k meets at PE(r,c).
  always_comb begin
    row_data_o = '0;
    col_data_o = '0;
    if (state == S_FEED) begin
      for (int r = 0; r < H; r++)
        for (int k = 0; k < K; k++)
          if (feed_cnt == FEED_W'(r + k)) row_data_o[r*width_p +: width_p] = a_mem[r][k];
      for (int c = 0; c < W; c++)
        for (int k = 0; k < K; k++)
          if (feed_cnt == FEED_W'(c + k)) col_data_o[c*width_p +: width_p] = b_mem[k][c];
    end
  end

  assign ready_o     = (state == S_LOAD);
  assign busy_o      = (state != S_LOAD);
  assign array_en_o  = (state == S_FEED) || (state == S_WAIT);
  assign array_clr_o = (state == S_CLEAR) || (state == S_DONE);
  assign valid_o     = (state == S_DRAIN);
  assign res_idx_o   = drain_cnt;
  assign data_o      = res_data_i;

endmodule

`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: drives operand jobs, models the MAC grid, scoreboards the result stream.
// Revision 1.0
`default_nettype none

module tb_systolic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, array_en_o, array_clr_o, valid_o, yumi_i, busy_o;
  logic [7:0]  data_i, res_data_i, data_o;
  logic [15:0] row_data_o, col_data_o;
  logic [1:0]  res_idx_o;

  always #5 clk = ~clk;

  systolic_sequencer dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .row_data_o  (row_data_o),
    .col_data_o  (col_data_o),
    .array_en_o  (array_en_o),
    .array_clr_o (array_clr_o),
    .res_idx_o   (res_idx_o),
    .res_data_i  (res_data_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .busy_o      (busy_o)
  );

  // Output-stationary 2x2 grid: operands hop east/south one PE per enabled step.
  logic [7:0] acc  [4];
  logic [7:0] hreg [2][2];
  logic [7:0] vreg [2][2];

  always @(posedge clk) begin : grid
    logic [7:0] ai, bi;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        if (array_clr_o) begin
          acc[r*2+c] <= 8'd0;
          hreg[r][c] <= 8'd0;
          vreg[r][c] <= 8'd0;
        end else if (array_en_o) begin
          if (c == 0) ai = row_data_o[r*8 +: 8];
          else        ai = hreg[r][c-1];
          if (r == 0) bi = col_data_o[c*8 +: 8];
          else        bi = vreg[r-1][c];
          acc[r*2+c] <= acc[r*2+c] + ai * bi;
          hreg[r][c] <= ai;
          vreg[r][c] <= bi;
        end
      end
  end

  assign res_data_i = acc[res_idx_o];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  int stall_left = 0;
  bit junk_yumi  = 1'b0;
  bit stalling   = 1'b0;

  // Result consumer: decides yumi at the negedge and scores the word it takes.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      yumi_i   = 1'b0;
      stalling = 1'b0;
    end else if (valid_o) begin
      if (stalling) check("stall_idx", res_idx_o, 1);
      if (res_idx_o == 2'd1 && stall_left > 0) begin
        stalling = 1'b1;
        stall_left--;
        yumi_i = 1'b0;
      end else begin
        stalling = 1'b0;
        yumi_i   = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("res_idx", res_idx_o, e.idx);
          check("res_data", data_o, e.val);
        end
      end
    end else begin
      if (stalling) check("stall_valid", valid_o, 1);
      stalling = 1'b0;
      yumi_i   = junk_yumi ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Loads one job; returns at the negedge after the last transfer.
  task automatic send_job(input logic [31:0] a_w, input logic [31:0] b_w, input bit gaps);
    logic [7:0] w [8];
    logic [7:0] sum;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      w[i]   = a_w[i*8 +: 8];
      w[i+4] = b_w[i*8 +: 8];
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        sum = 8'd0;
        for (int k = 0; k < 2; k++) sum = sum + w[r*2+k] * w[4+k*2+c];
        e.idx = r*2 + c;
        e.val = sum;
        exp_q.push_back(e);
      end
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        check("gap_ready", ready_o, 1);
        check("gap_no_en", array_en_o, 0);
      end
      @(negedge clk);
      check("load_ready", ready_o, 1);
      check("load_busy", busy_o, 0);
      check("load_noclr", array_clr_o, 0);
      valid_i = 1'b1;
      data_i  = w[i];
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_start_timeout", n < 200, 1);
    n = 0;
    while (!array_clr_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n < 200, 1);
    check("done_valid_low", valid_o, 0);
    check("drained", exp_q.size(), 0);
  endtask

  logic [15:0] row_exp [4] = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
  logic [15:0] col_exp [4] = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_en", array_en_o, 0);
    check("rst_clr", array_clr_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_idx", res_idx_o, 0);
    check("rst_row", row_data_o, 0);
    check("rst_col", col_data_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;

    // Reference job: clear pulse, skewed wavefronts, one wait step, then results.
    send_job(32'h04030201, 32'h08070605, 1'b0);
    check("clear_pulse", array_clr_o, 1);
    check("clear_en", array_en_o, 0);
    check("clear_busy", busy_o, 1);
    valid_i = 1'b1;
    data_i  = 8'hEE;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("feed_en", array_en_o, 1);
      check("feed_clr", array_clr_o, 0);
      check("feed_ready", ready_o, 0);
      check("feed_row", row_data_o, row_exp[t]);
      check("feed_col", col_data_o, col_exp[t]);
    end
    @(negedge clk);
    valid_i = 1'b0;
    check("wait_en", array_en_o, 1);
    check("wait_row", row_data_o, 0);
    check("wait_col", col_data_o, 0);
    check("wait_valid", valid_o, 0);
    @(negedge clk);
    check("first_valid", valid_o, 1);
    wait_done();

    // Backpressure at idx 1.
    stall_left = 5;
    send_job($urandom, $urandom, 1'b0);
    wait_done();
    check("stall_used", stall_left, 0);

    // Gapped input and stray yumi outside the drain.
    junk_yumi = 1'b1;
    send_job($urandom, $urandom, 1'b1);
    check("gap_clear_after_8th", array_clr_o, 1);
    wait_done();
    junk_yumi = 1'b0;

    // Reset in the middle of FEED discards the job.
    send_job($urandom, $urandom, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1);
    check("midrst_en", array_en_o, 0);
    check("midrst_valid", valid_o, 0);
    check("midrst_busy", busy_o, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_job(32'h04030201, 32'h08070605, 1'b0);
    wait_done();

    // Back-to-back: random job, then identity x identity straight after DONE.
    send_job($urandom, $urandom, 1'b0);
    wait_done();
    send_job(32'h01000001, 32'h01000001, 1'b0);
    wait_done();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
